// File: rtl/fht_frame_sched_if.sv
// Stream, bank-port and core handshake bundle between fht_frame_sched and its surroundings.
// master: the scheduler side; slave: the environment (source, banks, core, sink).
interface fht_frame_sched_if #(
  parameter int unsigned A_BIT = 8
) ();
  logic             iIN_VALID;
  logic             oIN_READY;
  logic             oLD_WE;
  logic [1:0]       oLD_BANK;
  logic [A_BIT-1:0] oLD_ADDR;
  logic             oFHT_START;
  logic             iFHT_RDY;
  logic             oUL_RE;
  logic [1:0]       oUL_BANK;
  logic [A_BIT-1:0] oUL_ADDR;
  logic             oOUT_VALID;
  logic             oOUT_LAST;
  logic             iOUT_READY;
  logic [1:0]       oMEM_SEL;
  logic             oBUSY;
  logic             oERR;
  logic [15:0]      oFRAME_CNT;

  modport master (
    input  iIN_VALID, iFHT_RDY, iOUT_READY,
    output oIN_READY, oLD_WE, oLD_BANK, oLD_ADDR, oFHT_START, oUL_RE, oUL_BANK, oUL_ADDR,
           oOUT_VALID, oOUT_LAST, oMEM_SEL, oBUSY, oERR, oFRAME_CNT
  );

  modport slave (
    output iIN_VALID, iFHT_RDY, iOUT_READY,
    input  oIN_READY, oLD_WE, oLD_BANK, oLD_ADDR, oFHT_START, oUL_RE, oUL_BANK, oUL_ADDR,
           oOUT_VALID, oOUT_LAST, oMEM_SEL, oBUSY, oERR, oFRAME_CNT
  );
endinterface

// File: rtl/fht_frame_sched.sv
// Frame scheduler: loads N = 4*2^A_BIT samples into the banks, kicks the FHT core,
// waits for completion and streams the results out, owning the bank-port select.
module fht_frame_sched #(
  parameter int unsigned A_BIT  = 8,
  parameter int unsigned WD_CYC = 16
) (
  input logic               iCLK,
  input logic               iRESET,
  fht_frame_sched_if.master bus
);

  localparam int unsigned NW = A_BIT + 2;
  localparam int unsigned N  = 4 * (2 ** A_BIT);
  localparam int unsigned WW = $clog2(WD_CYC + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWaitLo, StWaitHi, StUnload} state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   n_q, n_d;
  logic [NW:0]     m_q, m_d;
  logic [NW-1:0]   disp_q, disp_d;
  logic            valid_q, valid_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic            err_q, err_d;
  logic [15:0]     cnt_q, cnt_d;

  logic in_ready, ld_we, ul_re, out_last, out_acc;

  // Reset gates the input handshake so nothing is accepted during the reset cycle.
  assign in_ready = ((state_q == StIdle) || (state_q == StLoad)) && !iRESET;
  assign ld_we    = bus.iIN_VALID && in_ready;
  assign ul_re    = (state_q == StUnload) && !m_q[NW] && (!valid_q || bus.iOUT_READY);
  assign out_last = valid_q && (disp_q == NW'(N - 1));
  assign out_acc  = valid_q && bus.iOUT_READY;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= StIdle;
      n_q     <= '0;
      m_q     <= '0;
      disp_q  <= '0;
      valid_q <= 1'b0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      disp_q  <= disp_d;
      valid_q <= valid_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    m_d     = m_q;
    disp_d  = disp_q;
    valid_d = valid_q;
    wd_d    = wd_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (ld_we) begin
          n_d     = n_q + NW'(1);
          state_d = StLoad;
        end
      end
      StLoad: begin
        // n wraps back to 0 on the final accept, ready for the next frame.
        if (ld_we) begin
          n_d = n_q + NW'(1);
          if (n_q == '1) state_d = StStart;
        end
      end
      StStart: begin
        wd_d    = WW'(1);
        state_d = StWaitLo;
      end
      StWaitLo: begin
        if (!bus.iFHT_RDY) begin
          state_d = StWaitHi;
        end else if (wd_q >= WW'(WD_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      StWaitHi: begin
        if (bus.iFHT_RDY) begin
          m_d     = '0;
          valid_d = 1'b0;
          state_d = StUnload;
        end
      end
      StUnload: begin
        if (ul_re) begin
          m_d     = m_q + (NW + 1)'(1);
          disp_d  = m_q[NW-1:0];
          valid_d = 1'b1;
        end else if (bus.iOUT_READY) begin
          valid_d = 1'b0;
        end
        if (out_acc && out_last) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.oIN_READY  = in_ready;
    bus.oLD_WE     = ld_we;
    bus.oLD_BANK   = n_q[1:0];
    bus.oLD_ADDR   = n_q[NW-1:2];
    bus.oFHT_START = (state_q == StStart);
    bus.oUL_RE     = ul_re;
    bus.oUL_BANK   = m_q[1:0];
    bus.oUL_ADDR   = m_q[NW-1:2];
    bus.oOUT_VALID = valid_q;
    bus.oOUT_LAST  = out_last;
    bus.oBUSY      = (state_q != StIdle);
    bus.oERR       = err_q;
    bus.oFRAME_CNT = cnt_q;
    case (state_q)
      StStart, StWaitLo, StWaitHi: bus.oMEM_SEL = 2'd1;
      StUnload:                    bus.oMEM_SEL = 2'd2;
      default:                     bus.oMEM_SEL = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_fht_frame_sched.sv
// Directed bench for fht_frame_sched with A_BIT=2 (N=16) and WD_CYC=16.
module tb_fht_frame_sched;
  localparam int unsigned A_BIT  = 2;
  localparam int unsigned WD_CYC = 16;
  localparam int          N      = 16;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fht_frame_sched_if #(.A_BIT(A_BIT)) bus ();

  fht_frame_sched #(.A_BIT(A_BIT), .WD_CYC(WD_CYC)) dut (
    .iCLK  (clk),
    .iRESET(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Loads one frame starting in IDLE; ends one cycle into WAIT_LO.
  task automatic load_frame(input bit gaps, input int exp_cnt, input bit exp_err);
    int n;
    int c;
    bit v;
    n = 0;
    c = 0;
    while (n < N && c < 4 * N) begin
      v = !(gaps && (c % 3 == 2));
      bus.iIN_VALID = v;
      @(negedge clk);
      if (c == 0) begin
        chk("idle_busy", bus.oBUSY, 0);
        chk("idle_in_ready", bus.oIN_READY, 1);
        chk("idle_frame_cnt", bus.oFRAME_CNT, exp_cnt);
        chk("idle_err", bus.oERR, exp_err);
      end
      chk("ld_we", bus.oLD_WE, v);
      chk("ld_bank", bus.oLD_BANK, n % 4);
      chk("ld_addr", bus.oLD_ADDR, n / 4);
      chk("ld_mem_sel", bus.oMEM_SEL, 0);
      chk("ld_start", bus.oFHT_START, 0);
      chk("ld_ul_re", bus.oUL_RE, 0);
      if (v) n++;
      step();
      c++;
    end
    chk("ld_count", n, N);
    bus.iIN_VALID = 1'b1;
    @(negedge clk);
    chk("st_start", bus.oFHT_START, 1);
    chk("st_in_ready", bus.oIN_READY, 0);
    chk("st_ld_we", bus.oLD_WE, 0);
    chk("st_mem_sel", bus.oMEM_SEL, 1);
    chk("st_busy", bus.oBUSY, 1);
    step();
  endtask

  // Core drops RDY two cycles after start and raises it 100 cycles later.
  task automatic core_ok();
    @(negedge clk);
    chk("wl_start", bus.oFHT_START, 0);
    chk("wl_mem_sel", bus.oMEM_SEL, 1);
    step();
    bus.iFHT_RDY = 1'b0;
    repeat (100) begin
      @(negedge clk);
      chk("core_mem_sel", bus.oMEM_SEL, 1);
      chk("core_start", bus.oFHT_START, 0);
      chk("core_err", bus.oERR, 0);
      step();
    end
    bus.iFHT_RDY = 1'b1;
    @(negedge clk);
    chk("wh_mem_sel", bus.oMEM_SEL, 1);
    step();
  endtask

  // Drains one frame; returns one cycle after the last accept.
  task automatic unload(input bit toggle);
    int acc;
    int em;
    int c;
    bit pv;
    acc = 0;
    em  = 0;
    c   = 0;
    pv  = 1'b0;
    while (acc < N && c < 200) begin
      bus.iOUT_READY = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      chk("ul_mem_sel", bus.oMEM_SEL, 2);
      chk("ul_start", bus.oFHT_START, 0);
      if (pv) chk("ul_hold_valid", bus.oOUT_VALID, 1);
      if (bus.oUL_RE) begin
        chk("ul_bank", bus.oUL_BANK, em % 4);
        chk("ul_addr", bus.oUL_ADDR, em / 4);
        chk("ul_re_backpressure", bus.oOUT_VALID && !bus.iOUT_READY, 0);
        em++;
      end
      if (bus.oOUT_VALID && bus.iOUT_READY) begin
        chk("ul_last", bus.oOUT_LAST, acc == N - 1);
        acc++;
      end
      pv = bus.oOUT_VALID && !bus.iOUT_READY;
      step();
      c++;
    end
    chk("ul_accepts", acc, N);
    chk("ul_reads", em, N);
    bus.iOUT_READY = 1'b1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.iIN_VALID  = 1'b0;
    bus.iFHT_RDY   = 1'b1;
    bus.iOUT_READY = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_in_ready", bus.oIN_READY, 0);
    chk("rst_ld_we", bus.oLD_WE, 0);
    chk("rst_busy", bus.oBUSY, 0);
    chk("rst_mem_sel", bus.oMEM_SEL, 0);
    chk("rst_err", bus.oERR, 0);
    chk("rst_frame_cnt", bus.oFRAME_CNT, 0);
    chk("rst_start", bus.oFHT_START, 0);
    chk("rst_out_valid", bus.oOUT_VALID, 0);
    chk("rst_ul_re", bus.oUL_RE, 0);
    step();
    rst = 1'b0;

    // Frame 1 with full throughput, then frame 2 back-to-back with toggling ready.
    load_frame(1'b0, 0, 1'b0);
    core_ok();
    unload(1'b0);
    load_frame(1'b0, 1, 1'b0);
    core_ok();
    unload(1'b1);

    // Frame 3 with input gaps; core never drops RDY so the watchdog fires.
    load_frame(1'b1, 2, 1'b0);
    bus.iIN_VALID = 1'b0;
    for (int k = 1; k <= WD_CYC; k++) begin
      @(negedge clk);
      chk("wd_start", bus.oFHT_START, 0);
      if (k < WD_CYC) begin
        chk("wd_err_early", bus.oERR, 0);
        chk("wd_busy_early", bus.oBUSY, 1);
      end else begin
        chk("wd_err", bus.oERR, 1);
        chk("wd_busy", bus.oBUSY, 0);
        chk("wd_in_ready", bus.oIN_READY, 1);
        chk("wd_mem_sel", bus.oMEM_SEL, 0);
      end
      step();
    end

    // RDY falling in IDLE is ignored.
    bus.iFHT_RDY = 1'b0;
    step();
    @(negedge clk);
    chk("idle_rdy_busy", bus.oBUSY, 0);
    chk("idle_rdy_err", bus.oERR, 1);
    step();
    bus.iFHT_RDY = 1'b1;

    // Reset while sample 7 is being offered drops the partial frame.
    bus.iIN_VALID = 1'b1;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      chk("part_bank", bus.oLD_BANK, n % 4);
      chk("part_addr", bus.oLD_ADDR, n / 4);
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    chk("part_rst_ld_we", bus.oLD_WE, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", bus.oBUSY, 0);
    chk("post_rst_start", bus.oFHT_START, 0);
    chk("post_rst_out_valid", bus.oOUT_VALID, 0);
    chk("post_rst_mem_sel", bus.oMEM_SEL, 0);
    chk("post_rst_bank", bus.oLD_BANK, 0);
    chk("post_rst_addr", bus.oLD_ADDR, 0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    load_frame(1'b0, 0, 1'b0);
    core_ok();
    unload(1'b0);
    bus.iIN_VALID = 1'b0;
    @(negedge clk);
    chk("final_frame_cnt", bus.oFRAME_CNT, 1);
    chk("final_busy", bus.oBUSY, 0);
    chk("final_mem_sel", bus.oMEM_SEL, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
